// File: rtl/tdc_peak_sorter.sv
// tdc_peak_sorter: ranks one frame of N_CH TDC return peaks by intensity and presents
// the K strongest (descending, stable on ties) with their ToF and source channel.
// Latency: out_valid rises N_CH cycles after the accept edge; one frame per N_CH+2 cycles.
// Backpressure: in_ready only in IDLE; results held in DONE until out_ready; flush aborts.
//
// Ports:
//   clk, rst_n (async, active-low), flush (sync abort of frame in flight)
//   in_valid/in_ready, in_int[N_CH*IW], in_tof[N_CH*TW], in_vld[N_CH]   - input frame
//   out_valid/out_ready, out_int[K*IW], out_tof[K*TW], out_idx[K*IDXW],
//   out_slot_vld[K], out_cnt[CW]                                         - ranked result
module tdc_peak_sorter #(
    parameter int N_CH = 8,
    parameter int IW   = 5,
    parameter int TW   = 16,
    parameter int K    = 3,
    localparam int IDXW = $clog2(N_CH),
    localparam int CW   = $clog2(K + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_CH*IW-1:0]   in_int,
    input  logic [N_CH*TW-1:0]   in_tof,
    input  logic [N_CH-1:0]      in_vld,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [K*IW-1:0]      out_int,
    output logic [K*TW-1:0]      out_tof,
    output logic [K*IDXW-1:0]    out_idx,
    output logic [K-1:0]         out_slot_vld,
    output logic [CW-1:0]        out_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SORT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [IDXW-1:0] pass_q, pass_d;

    logic [IW-1:0]   int_q [N_CH];
    logic [IW-1:0]   int_d [N_CH];
    logic [IW-1:0]   srt_int [N_CH];
    logic [TW-1:0]   tof_q [N_CH];
    logic [TW-1:0]   tof_d [N_CH];
    logic [TW-1:0]   srt_tof [N_CH];
    logic [IDXW-1:0] idx_q [N_CH];
    logic [IDXW-1:0] idx_d [N_CH];
    logic [IDXW-1:0] srt_idx [N_CH];
    logic            vld_q [N_CH];
    logic            vld_d [N_CH];
    logic            srt_vld [N_CH];

    logic                out_valid_q, out_valid_d;
    logic [K*IW-1:0]     out_int_q, out_int_d;
    logic [K*TW-1:0]     out_tof_q, out_tof_d;
    logic [K*IDXW-1:0]   out_idx_q, out_idx_d;
    logic [K-1:0]        out_slot_q, out_slot_d;
    logic [CW-1:0]       out_cnt_q, out_cnt_d;
    logic [CW-1:0]       cnt_c;

    // One odd-even transposition pass. Pass parity selects the pair grid; swapping only
    // on a strictly larger {vld,int} key keeps equal keys in channel order, and puts
    // every masked channel below every valid one.
    always_comb begin
        srt_int = int_q;
        srt_tof = tof_q;
        srt_idx = idx_q;
        srt_vld = vld_q;
        for (int j = 0; j < N_CH - 1; j++) begin
            if ((j[0] == pass_q[0]) &&
                ({vld_q[j+1], int_q[j+1]} > {vld_q[j], int_q[j]})) begin
                srt_int[j]   = int_q[j+1];
                srt_int[j+1] = int_q[j];
                srt_tof[j]   = tof_q[j+1];
                srt_tof[j+1] = tof_q[j];
                srt_idx[j]   = idx_q[j+1];
                srt_idx[j+1] = idx_q[j];
                srt_vld[j]   = vld_q[j+1];
                srt_vld[j+1] = vld_q[j];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        int_d       = int_q;
        tof_d       = tof_q;
        idx_d       = idx_q;
        vld_d       = vld_q;
        out_valid_d = out_valid_q;
        out_int_d   = out_int_q;
        out_tof_d   = out_tof_q;
        out_idx_d   = out_idx_q;
        out_slot_d  = out_slot_q;
        out_cnt_d   = out_cnt_q;
        cnt_c       = '0;

        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < N_CH; i++) begin
                            int_d[i] = in_int[i*IW +: IW];
                            tof_d[i] = in_tof[i*TW +: TW];
                            idx_d[i] = IDXW'(i);
                            vld_d[i] = in_vld[i];
                        end
                        pass_d  = '0;
                        state_d = ST_SORT;
                    end
                end
                ST_SORT: begin
                    int_d  = srt_int;
                    tof_d  = srt_tof;
                    idx_d  = srt_idx;
                    vld_d  = srt_vld;
                    pass_d = pass_q + 1'b1;
                    if (pass_q == IDXW'(N_CH - 1)) begin
                        // Take the top K straight from this final pass; empty slots read 0.
                        for (int k = 0; k < K; k++) begin
                            out_int_d[k*IW +: IW]     = srt_vld[k] ? srt_int[k] : '0;
                            out_tof_d[k*TW +: TW]     = srt_vld[k] ? srt_tof[k] : '0;
                            out_idx_d[k*IDXW +: IDXW] = srt_vld[k] ? srt_idx[k] : '0;
                            out_slot_d[k]             = srt_vld[k];
                            cnt_c                     = cnt_c + CW'(srt_vld[k]);
                        end
                        out_cnt_d   = cnt_c;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pass_q      <= '0;
            for (int i = 0; i < N_CH; i++) begin
                int_q[i] <= '0;
                tof_q[i] <= '0;
                idx_q[i] <= '0;
                vld_q[i] <= 1'b0;
            end
            out_valid_q <= 1'b0;
            out_int_q   <= '0;
            out_tof_q   <= '0;
            out_idx_q   <= '0;
            out_slot_q  <= '0;
            out_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            int_q       <= int_d;
            tof_q       <= tof_d;
            idx_q       <= idx_d;
            vld_q       <= vld_d;
            out_valid_q <= out_valid_d;
            out_int_q   <= out_int_d;
            out_tof_q   <= out_tof_d;
            out_idx_q   <= out_idx_d;
            out_slot_q  <= out_slot_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = out_valid_q;
    assign out_int      = out_int_q;
    assign out_tof      = out_tof_q;
    assign out_idx      = out_idx_q;
    assign out_slot_vld = out_slot_q;
    assign out_cnt      = out_cnt_q;

endmodule

// File: tb/tb_tdc_peak_sorter.sv
// Bench for tdc_peak_sorter: table of frames with hand-derived rankings, handshake and
// flush/reset corner sequences, and random frames ranked by a selection model.
// Expected results are queued at accept time and popped when the DUT presents a result.
module tb_tdc_peak_sorter;

    localparam int N_CH = 8;
    localparam int IW   = 5;
    localparam int TW   = 16;
    localparam int K    = 3;
    localparam int IDXW = 3;
    localparam int CW   = 2;

    typedef struct packed {
        logic [N_CH-1:0][IW-1:0] i_int;
        logic [N_CH-1:0][TW-1:0] i_tof;
        logic [N_CH-1:0]         i_vld;
        logic [K-1:0][IW-1:0]    e_int;
        logic [K-1:0][TW-1:0]    e_tof;
        logic [K-1:0][IDXW-1:0]  e_idx;
        logic [K-1:0]            e_slot;
        logic [CW-1:0]           e_cnt;
    } rec_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [N_CH*IW-1:0]   in_int;
    logic [N_CH*TW-1:0]   in_tof;
    logic [N_CH-1:0]      in_vld;
    logic                 out_valid;
    logic                 out_ready;
    logic [K*IW-1:0]      out_int;
    logic [K*TW-1:0]      out_tof;
    logic [K*IDXW-1:0]    out_idx;
    logic [K-1:0]         out_slot_vld;
    logic [CW-1:0]        out_cnt;

    int   n_chk = 0;
    int   n_err = 0;
    rec_t tab [6];
    rec_t sb_q [$];

    tdc_peak_sorter #(.N_CH(N_CH), .IW(IW), .TW(TW), .K(K)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_int(in_int), .in_tof(in_tof), .in_vld(in_vld),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_int(out_int), .out_tof(out_tof), .out_idx(out_idx),
        .out_slot_vld(out_slot_vld), .out_cnt(out_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference ranking by repeated max-selection; lowest channel wins ties.
    function automatic rec_t model(input rec_t r);
        rec_t        m;
        logic [N_CH-1:0] used;
        int          best;
        m        = r;
        m.e_int  = '0;
        m.e_tof  = '0;
        m.e_idx  = '0;
        m.e_slot = '0;
        m.e_cnt  = '0;
        used     = '0;
        for (int k = 0; k < K; k++) begin
            best = -1;
            for (int i = 0; i < N_CH; i++)
                if (!used[i] && r.i_vld[i] && (best < 0 || r.i_int[i] > r.i_int[best]))
                    best = i;
            if (best >= 0) begin
                used[best]  = 1'b1;
                m.e_int[k]  = r.i_int[best];
                m.e_tof[k]  = r.i_tof[best];
                m.e_idx[k]  = IDXW'(best);
                m.e_slot[k] = 1'b1;
                m.e_cnt     = m.e_cnt + 1'b1;
            end
        end
        return m;
    endfunction

    // Drive one frame; on return we sit at the negedge just after the accept edge.
    task automatic accept(input rec_t r);
        int c = 0;
        @(negedge clk);
        while (!in_ready && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("in_ready_before_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_int   = r.i_int;
        in_tof   = r.i_tof;
        in_vld   = r.i_vld;
        sb_q.push_back(r);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result();
        rec_t e;
        if (sb_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL scoreboard: result with empty queue");
            return;
        end
        e = sb_q.pop_front();
        chk("out_valid", 64'(out_valid), 64'd1);
        chk("out_int", 64'(out_int), 64'(e.e_int));
        chk("out_tof", 64'(out_tof), 64'(e.e_tof));
        chk("out_idx", 64'(out_idx), 64'(e.e_idx));
        chk("out_slot_vld", 64'(out_slot_vld), 64'(e.e_slot));
        chk("out_cnt", 64'(out_cnt), 64'(e.e_cnt));
    endtask

    task automatic run_frame(input rec_t r, input int hold);
        int lat;
        accept(r);
        wait_valid(lat);
        chk("latency", 64'(lat), 64'd8);
        for (int h = 0; h < hold; h++) begin
            chk("hold_int", 64'(out_int), 64'(r.e_int));
            chk("hold_idx", 64'(out_idx), 64'(r.e_idx));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_valid", 64'(out_valid), 64'd1);
            @(negedge clk);
        end
        check_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", 64'(out_valid), 64'd0);
        chk("in_ready_after", 64'(in_ready), 64'd1);
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        logic seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk(name, 64'(seen), 64'd0);
    endtask

    initial begin
        rec_t r;
        int   lat;

        for (int n = 0; n < 6; n++) begin
            tab[n] = '0;
            for (int i = 0; i < N_CH; i++) tab[n].i_tof[i] = 16'(i * 100);
        end
        // 0: mixed intensities, all valid, tie 17/17 keeps ch1 before ch5
        tab[0].i_int  = {5'd2, 5'd5, 5'd17, 5'd0, 5'd31, 5'd9, 5'd17, 5'd3};
        tab[0].i_vld  = 8'hFF;
        tab[0].e_int  = {5'd17, 5'd17, 5'd31};
        tab[0].e_tof  = {16'd500, 16'd100, 16'd300};
        tab[0].e_idx  = {3'd5, 3'd1, 3'd3};
        tab[0].e_slot = 3'b111;
        tab[0].e_cnt  = 2'd3;
        // 1: all equal -> channel order
        for (int i = 0; i < N_CH; i++) tab[1].i_int[i] = 5'd7;
        tab[1].i_vld  = 8'hFF;
        tab[1].e_int  = {5'd7, 5'd7, 5'd7};
        tab[1].e_tof  = {16'd200, 16'd100, 16'd0};
        tab[1].e_idx  = {3'd2, 3'd1, 3'd0};
        tab[1].e_slot = 3'b111;
        tab[1].e_cnt  = 2'd3;
        // 2: only ch6 valid, masked channels carry larger intensities
        for (int i = 0; i < N_CH; i++) tab[2].i_int[i] = 5'd31;
        tab[2].i_int[6] = 5'd4;
        tab[2].i_tof[6] = 16'h1234;
        tab[2].i_vld  = 8'h40;
        tab[2].e_int  = {5'd0, 5'd0, 5'd4};
        tab[2].e_tof  = {16'd0, 16'd0, 16'h1234};
        tab[2].e_idx  = {3'd0, 3'd0, 3'd6};
        tab[2].e_slot = 3'b001;
        tab[2].e_cnt  = 2'd1;
        // 3: nothing valid
        for (int i = 0; i < N_CH; i++) tab[3].i_int[i] = 5'(i * 3);
        tab[3].i_vld  = 8'h00;
        // 4: two valid peaks at the ends of the array
        for (int i = 0; i < N_CH; i++) tab[4].i_int[i] = 5'd31;
        tab[4].i_int[0] = 5'd2;
        tab[4].i_int[7] = 5'd9;
        tab[4].i_vld  = 8'h81;
        tab[4].e_int  = {5'd0, 5'd2, 5'd9};
        tab[4].e_tof  = {16'd0, 16'd0, 16'd700};
        tab[4].e_idx  = {3'd0, 3'd0, 3'd7};
        tab[4].e_slot = 3'b011;
        tab[4].e_cnt  = 2'd2;
        // 5: three-way tie among valid channels, stronger masked channel ignored
        tab[5].i_int  = {5'd12, 5'd0, 5'd1, 5'd12, 5'd25, 5'd12, 5'd4, 5'd30};
        tab[5].i_vld  = 8'b1011_0110;
        tab[5].e_int  = {5'd12, 5'd12, 5'd12};
        tab[5].e_tof  = {16'd700, 16'd400, 16'd200};
        tab[5].e_idx  = {3'd7, 3'd4, 3'd2};
        tab[5].e_slot = 3'b111;
        tab[5].e_cnt  = 2'd3;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_int = '0; in_tof = '0; in_vld = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_int", 64'(out_int), 64'd0);
        chk("rst_out_cnt", 64'(out_cnt), 64'd0);
        rst_n = 1'b1;

        for (int n = 0; n < 6; n++) run_frame(tab[n], 0);

        // consumer stalls 5 cycles in DONE
        run_frame(tab[0], 5);

        // flush during the third sort cycle
        accept(tab[0]);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        void'(sb_q.pop_front());
        expect_quiet("flush_no_result", 12);
        run_frame(tab[0], 0);

        // flush coincident with an offered frame: nothing captured
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1;
        in_int = tab[1].i_int; in_tof = tab[1].i_tof; in_vld = tab[1].i_vld;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_accept_in_ready", 64'(in_ready), 64'd1);
        expect_quiet("flush_accept_no_result", 12);

        // flush in DONE wins over out_ready
        accept(tab[1]);
        wait_valid(lat);
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b0;
        chk("flush_done_valid", 64'(out_valid), 64'd0);
        chk("flush_done_in_ready", 64'(in_ready), 64'd1);
        void'(sb_q.pop_front());

        // asynchronous reset while holding a result
        accept(tab[4]);
        wait_valid(lat);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_int", 64'(out_int), 64'd0);
        chk("arst_out_idx", 64'(out_idx), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        void'(sb_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(tab[5], 0);

        // random frames with narrow intensity range to provoke ties
        for (int n = 0; n < 24; n++) begin
            r = '0;
            for (int i = 0; i < N_CH; i++) begin
                r.i_int[i] = 5'($urandom_range(0, 7));
                r.i_tof[i] = 16'($urandom);
            end
            r.i_vld = 8'($urandom);
            run_frame(model(r), int'($urandom_range(0, 2)));
        end

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
